// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcodes consumed by the main decoder,
// instruction kinds accepted by the loader, field widths and FSM states.
package mips_pkg;

    localparam int WORD_W   = 32;
    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int SHAMT_W  = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int TARGET_W = 26;
    localparam int KIND_W   = 3;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    // Codes 6 and 7 are deliberately left out: they are the illegal kinds.
    typedef enum logic [KIND_W-1:0] {
        KIND_RTYPE = 3'd0,
        KIND_LW    = 3'd1,
        KIND_SW    = 3'd2,
        KIND_BEQ   = 3'd3,
        KIND_ADDI  = 3'd4,
        KIND_J     = 3'd5
    } instr_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Symbolic-instruction handshake: the producer (master) presents one
// instruction per beat; the encoder (slave) accepts it when in_ready is high.
interface instr_encoder_if;
    import mips_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [KIND_W-1:0]   in_kind;
    logic [REG_W-1:0]    in_rs;
    logic [REG_W-1:0]    in_rt;
    logic [REG_W-1:0]    in_rd;
    logic [SHAMT_W-1:0]  in_shamt;
    logic [FUNCT_W-1:0]  in_funct;
    logic [IMM_W-1:0]    in_imm;
    logic [TARGET_W-1:0] in_target;
    logic                in_last;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt,
               in_funct, in_imm, in_target, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt,
               in_funct, in_imm, in_target, in_last,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational packer: instruction kind plus fields -> 32-bit MIPS word.
// Kinds outside the legal set produce a zero word and raise o_illegal.
module instr_pack
    import mips_pkg::*;
(
    input  logic [KIND_W-1:0]   i_kind,
    input  logic [REG_W-1:0]    i_rs,
    input  logic [REG_W-1:0]    i_rt,
    input  logic [REG_W-1:0]    i_rd,
    input  logic [SHAMT_W-1:0]  i_shamt,
    input  logic [FUNCT_W-1:0]  i_funct,
    input  logic [IMM_W-1:0]    i_imm,
    input  logic [TARGET_W-1:0] i_target,
    output logic [WORD_W-1:0]   o_word,
    output logic                o_illegal
);

    // Select the field layout for the requested kind.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missed
        // branch would otherwise infer a latch.
        o_word    = '0;
        o_illegal = 1'b0;
        case (instr_kind_e'(i_kind))
            KIND_RTYPE: o_word = {OP_RTYPE, i_rs, i_rt, i_rd, i_shamt, i_funct};
            KIND_LW:    o_word = {OP_LW,    i_rs, i_rt, i_imm};
            KIND_SW:    o_word = {OP_SW,    i_rs, i_rt, i_imm};
            KIND_BEQ:   o_word = {OP_BEQ,   i_rs, i_rt, i_imm};
            KIND_ADDI:  o_word = {OP_ADDI,  i_rs, i_rt, i_imm};
            KIND_J:     o_word = {OP_J,     i_target};
            default:    o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction-memory loader: encodes accepted instructions, writes them to
// consecutive word addresses and holds the core in reset until the program
// is completely written.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    instr_encoder_if.slave        in_if,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [WORD_W-1:0]     o_imem_wdata,
    output logic                  o_cpu_rst_n,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [ADDR_WIDTH:0]   o_count
);

    localparam logic [ADDR_WIDTH:0] DEPTH     = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = DEPTH - 1'b1;

    enc_state_e              r_state;
    enc_state_e              w_next_state;
    logic [ADDR_WIDTH:0]     r_ptr;
    logic                    r_pending_last;
    logic                    r_error;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [WORD_W-1:0]       r_wdata;
    logic                    r_cpu_rst_n;

    logic                    w_full;
    logic                    w_busy;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_write;
    logic                    w_start_ok;
    logic [WORD_W-1:0]       w_word;
    logic                    w_illegal;

    instr_pack u_pack (
        .i_kind    (in_if.in_kind),
        .i_rs      (in_if.in_rs),
        .i_rt      (in_if.in_rt),
        .i_rd      (in_if.in_rd),
        .i_shamt   (in_if.in_shamt),
        .i_funct   (in_if.in_funct),
        .i_imm     (in_if.in_imm),
        .i_target  (in_if.in_target),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    // Handshake: stop accepting once memory is full or the last beat is in.
    assign w_full     = (r_ptr == DEPTH);
    assign w_busy     = (r_state == ST_LOAD);
    assign w_ready    = w_busy && !w_full && !r_pending_last;
    assign w_accept   = in_if.in_valid && w_ready;
    assign w_write    = w_accept && !w_illegal;
    assign w_start_ok = i_start && (r_state != ST_LOAD);

    assign in_if.in_ready = w_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: finish one cycle after the last beat or the final slot is
    // written, so the core only leaves reset after the closing write.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next_state = ST_LOAD;
            ST_LOAD: if (r_pending_last || w_full) w_next_state = ST_DONE;
            ST_DONE: if (i_start) w_next_state = ST_LOAD;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Pointer, sticky error, registered memory write port and core reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr          <= '0;
            r_pending_last <= 1'b0;
            r_error        <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_cpu_rst_n    <= 1'b0;
        end else begin
            r_we        <= w_write;
            r_cpu_rst_n <= (w_next_state == ST_DONE);
            if (w_start_ok) begin
                r_ptr          <= '0;
                r_pending_last <= 1'b0;
                r_error        <= 1'b0;
            end else if (w_accept) begin
                if (in_if.in_last) begin
                    r_pending_last <= 1'b1;
                end
                if (w_illegal) begin
                    // Consumed but not written: pointer stays put.
                    r_error <= 1'b1;
                end else begin
                    r_ptr   <= r_ptr + 1'b1;
                    r_addr  <= r_ptr[ADDR_WIDTH-1:0];
                    r_wdata <= w_word;
                    // Filling the final slot without a terminating beat.
                    if (!in_if.in_last && r_ptr == LAST_ADDR) begin
                        r_error <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_imem_we    = r_we;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_cpu_rst_n  = r_cpu_rst_n;
    assign o_busy       = w_busy;
    assign o_done       = (r_state == ST_DONE);
    assign o_error      = r_error;
    assign o_count      = r_ptr;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction-memory loader and encoder: it is the opposite end of the main decoder's opcode interface. It accepts symbolic instructions (kind plus fields) over a valid/ready handshake and packs them into 32-bit MIPS words using the same opcode set the main decoder consumes (R-type, lw, sw, beq, addi, j). It writes the words sequentially into instruction memory and holds the single-cycle core in reset until a program load completes.

## Interface
- ADDR_WIDTH, 6, word-address width of instruction memory; DEPTH = 2**ADDR_WIDTH words
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a load session; honoured in IDLE or DONE only
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block can accept an instruction this cycle
- in_kind  in  3  0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J; 6–7 illegal
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields
- in_funct  in  6  R-type function
- in_imm  in  16  I-type immediate
- in_target  in  26  J-type target
- in_last  in  1  final instruction of the program
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_WIDTH  word address
- imem_wdata  out  32  encoded instruction
- cpu_rst_n  out  1  active-low reset to the core; 0 while not loaded
- busy  out  1  state == LOAD
- done  out  1  state == DONE
- error  out  1  sticky: illegal kind consumed, or memory full without in_last
- count  out  ADDR_WIDTH+1  words written in the current session

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE –start→ LOAD.
  - LOAD –accepted beat with in_last, or DEPTH-th word written→ DONE.
  - DONE –start→ LOAD.
  - start during LOAD is ignored.
- Entering LOAD clears the write pointer, count and error, and drives cpu_rst_n = 0.
- in_ready = busy && !full && !pending_last. A beat is accepted when in_valid && in_ready.
- Encoding, MSB first:
  - RTYPE: {000000, rs, rt, rd, shamt, funct}
  - LW: {100011, rs, rt, imm}
  - SW: {101011, rs, rt, imm}
  - BEQ: {000100, rs, rt, imm}
  - ADDI: {001000, rs, rt, imm}
  - J: {000010, target}
  - Fields unused by a kind are ignored.
- Illegal kind (6–7): the beat is consumed, nothing is written, the pointer does not advance, and error is set. If in_last is also set, the FSM still goes to DONE.
- Pointer increments by 1 per written word; count = pointer. Once count == DEPTH, full = 1 and in_ready = 0.
- If the word at address DEPTH-1 is written without in_last, the FSM goes to DONE with error = 1. There is no wrap-around.
- cpu_rst_n = 1 only in DONE and is registered, so it is glitch-free.

## Timing
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_rst_n 0, busy 0, done 0, error 0, count 0.
- start sampled in cycle N → busy = 1 and in_ready = 1 in N+1.
- Accept in cycle N → imem_we = 1 with imem_addr = pointer and imem_wdata = encoded word in N+1 (one registered stage). count updates in N+1.
- Back-to-back accepts sustain one write per cycle.
- Accept with in_last in cycle N → in_ready drops in N+1 and the last write occurs in N+1. done = 1 and cpu_rst_n = 1 in N+2, so the core never leaves reset before the final write.
- The DEPTH-th write in N+1 → done in N+2.
- Asynchronous reset mid-load: immediately return to IDLE. imem_we drops and cpu_rst_n = 0. The partial program is not resumed.
- imem_addr and imem_wdata hold their last values when imem_we = 0.

## Structure
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, also used by the main decoder
  - instruction-kind constants
  - field-width constants
- One sub-module, instr_pack: combinational, kind + fields → {word, illegal}. It is shared with the bench's reference model.
- The top level holds the FSM, pointer/count, output register and sticky error.

## Test plan
- Reset, start, then add $3,$1,$2 (RTYPE rs1 rt2 rd3 funct 0x20) with in_last → write 0x00221820 at addr 0, then done = 1, cpu_rst_n = 1, count = 1.
- Back-to-back lw $2,4($1); sw $2,8($1); beq $1,$2,-1; addi $1,$0,5; j 0x10 (last) → consecutive writes 0x8C220004, 0x AC220008 (0xAC220008), 0x1022FFFF, 0x20010005, 0x08000010 at addresses 0–4, one per cycle, count = 5.
- Kind 7 between two addi beats → only two writes, at addresses 0 and 1. error = 1 and stays set in DONE.
- ADDR_WIDTH = 2: five beats with in_last only on the fifth → four writes to addresses 0–3. in_ready = 0 after the fourth accept, DONE with error = 1, the fifth beat is never accepted.
- in_valid toggled randomly, plus start asserted during LOAD → start has no effect, no write without a prior accept, words stay in order.
- rst_n pulsed low after two writes, then start and reload → IDLE immediately with cpu_rst_n = 0. The new session writes from addr 0 with count and error cleared.
